dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Responder end of the core's data-memory interface. Serves the core's load/store requests: address, write data, memory enable, write enable and byte-lane enables in; one read word out.
Contains a word-organised data RAM plus a small MMIO block: a halt/tohost register, a console TX FIFO with valid/ready drain port, and a free-running 64-bit cycle timer.
Sits beside the single-cycle core in the testbench/top level, so reads are combinational and writes commit at the clock edge.

Parameters:
RAM_BASE, 32'h0000_2000, byte base address of data RAM
RAM_WORDS, 1024, RAM depth in 32-bit words (power of two)
MMIO_BASE, 32'h8000_0000, byte base of 16-byte MMIO window
TXQ_DEPTH, 4, console FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
IEUAdr  in  32  byte address of access
WriteData  in  32  store data, already lane-aligned by the core
MemEn  in  1  access valid this cycle
WriteEn  in  1  1=store, 0=load (qualified by MemEn)
WriteByteEn  in  4  byte-lane enables for stores
ReadData  out  32  load data, combinational from address
ConsoleValid  out  1  FIFO head valid
ConsoleData  out  8  FIFO head byte
ConsoleReady  in  1  consumer accepts head when Valid&Ready
Halt  out  1  sticky: program wrote tohost
HaltCode  out  31  tohost value [31:1] captured at halt
BusErr  out  1  sticky: access outside RAM and MMIO windows

Behaviour:
- Decode:
  - RAM hit when RAM_BASE <= IEUAdr < RAM_BASE+4*RAM_WORDS.
  - MMIO hit when IEUAdr[31:4]==MMIO_BASE[31:4].
  - IEUAdr[1:0] ignored for word selection.
- Loads:
  - ReadData is combinational whenever MemEn=1 and WriteEn=0; it returns the whole word and the core extracts bytes/halfwords.
  - MemEn=0 or a miss -> ReadData=0.
- RAM stores: on clk edge when MemEn&WriteEn&hit, write each byte lane i where WriteByteEn[i]=1; other lanes are unchanged.
- RAM contents are not reset; uninitialised RAM reads X in simulation.
- MMIO map (offset from MMIO_BASE):
  - +0x0 TOHOST:
    - Store with byte lane 0 enabled and WriteData[0]=1 sets Halt=1 and HaltCode=WriteData[31:1].
    - WriteData[0]=0 is ignored.
    - Reads return {HaltCode,Halt}.
  - +0x4 CONSOLE:
    - Store with WriteByteEn[0]=1 pushes WriteData[7:0] into the FIFO.
    - Read returns {29'b0, overflow, full, empty}.
  - +0x8 MTIME_LO, +0xC MTIME_HI: read-only halves of the 64-bit timer; stores ignored.
- Console FIFO:
  - Circular buffer, TXQ_DEPTH entries; pointers carry an extra wrap bit, so full is distinguished from empty.
  - ConsoleValid = !empty; ConsoleData = head entry.
  - Pop when ConsoleValid&ConsoleReady.
  - Push accepted if !full, or if full with a pop in the same cycle (count unchanged, ordering preserved).
  - Push when full with no pop: byte dropped, overflow bit set (sticky until reset).
  - Push and pop on an empty FIFO: the pushed byte becomes the head next cycle; no bypass, so Valid rises one cycle after the store.
- Timer: increments by 1 every cycle after reset deassertion; wraps 2^64-1 -> 0.
- Halt:
  - Once Halt=1, all further stores (RAM and MMIO) are ignored and the timer freezes.
  - Loads and FIFO draining continue.
- BusErr: set on any MemEn=1 cycle that misses both windows; sticky. Miss stores have no effect.
- Reset (async assert, any cycle including mid-drain):
  - Halt=0, HaltCode=0, BusErr=0.
  - FIFO empty, overflow=0, ConsoleValid=0, ConsoleData=0.
  - Timer=0.
  - RAM untouched.

Optional Feature:
DMEM_MTIME_EN:
- Defined: timer implemented as above.
- Undefined: no timer flops; MTIME_LO/HI read 0; Halt freeze applies only to stores.

Test Plan:
- Byte-lane store:
  - Store 32'hDEADBEEF, WriteByteEn=4'hF to 0x2000.
  - Store 32'h0000_5500, WriteByteEn=4'b0010 to 0x2000.
  - Load 0x2000 -> 32'hDEAD55EF.
- FIFO fill/overflow:
  - With ConsoleReady=0, store 'A','B','C','D','E' to 0x8000_0004.
  - CONSOLE read -> 32'h6 (full, overflow).
  - Raise ConsoleReady -> bytes 0x41..0x44 drained in order over 4 cycles, then ConsoleValid=0.
- Simultaneous push/pop when full:
  - Hold the FIFO full with ConsoleReady=1 and store 'Z' in the same cycle.
  - Required: no overflow; 'Z' emerges fifth.
- Halt:
  - Store 32'h0000_0007 to 0x8000_0000 -> Halt=1, HaltCode=3.
  - Subsequent store 32'h1 to 0x2000 leaves RAM unchanged.
  - MTIME_LO is constant across reads (DMEM_MTIME_EN defined).
- Timer: 10 cycles after reset release, MTIME_LO reads 10 (+/-0, defined sample point); MTIME_HI reads 0.
- Errors and reset:
  - Load 0x0000_1000 -> ReadData=0, BusErr=1.
  - Assert reset mid-drain -> ConsoleValid=0, BusErr=0, Halt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the core's data-memory bus and the console drain handshake so the
// responder and its environment connect through a single port.
//
// Signals:
//   IEUAdr       byte address of the access
//   WriteData    store data, already lane-aligned by the core
//   MemEn        access valid this cycle
//   WriteEn      1 = store, 0 = load (qualified by MemEn)
//   WriteByteEn  byte-lane enables for stores
//   ReadData     load data, combinational from the address
//   ConsoleValid console FIFO head is valid
//   ConsoleData  console FIFO head byte
//   ConsoleReady consumer accepts the head when Valid & Ready
//
// Modports:
//   master  core / console-consumer side
//   slave   the data-memory responder
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic [31:0] IEUAdr;
    logic [31:0] WriteData;
    logic        MemEn;
    logic        WriteEn;
    logic [3:0]  WriteByteEn;
    logic [31:0] ReadData;
    logic        ConsoleValid;
    logic [7:0]  ConsoleData;
    logic        ConsoleReady;

    modport master (
        output IEUAdr, WriteData, MemEn, WriteEn, WriteByteEn, ConsoleReady,
        input  ReadData, ConsoleValid, ConsoleData
    );

    modport slave (
        input  IEUAdr, WriteData, MemEn, WriteEn, WriteByteEn, ConsoleReady,
        output ReadData, ConsoleValid, ConsoleData
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the single-cycle core's data-memory interface. Holds a
// word-organised data RAM and a 16-byte MMIO window containing:
//   +0x0 TOHOST   halt register (write bit0=1 to halt, reads {HaltCode,Halt})
//   +0x4 CONSOLE  push a byte into the TX FIFO; reads {overflow,full,empty}
//   +0x8 MTIME_LO / +0xC MTIME_HI  read-only 64-bit cycle timer
// Loads are combinational, stores commit on the rising clock edge.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous active-high reset
//   bus       dmem_responder_if.slave (memory bus + console drain port)
//   Halt      sticky, set when the program writes tohost
//   HaltCode  tohost value [31:1] captured at halt
//   BusErr    sticky, set by any access outside the RAM and MMIO windows
//
// Configuration macro:
//   DMEM_MTIME_EN  when defined, the 64-bit cycle timer is built; otherwise
//                  MTIME_LO/HI read as zero and no timer flops exist.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          TXQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus,
    output logic               Halt,
    output logic [30:0]        HaltCode,
    output logic               BusErr
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          QW        = $clog2(TXQ_DEPTH);
    localparam logic [31:0] RAM_LIMIT = RAM_BASE + 32'(4 * RAM_WORDS);

    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    mmio_off;
    logic          store;
    logic          load;

    logic [7:0]    txq [TXQ_DEPTH];
    logic [QW:0]   wr_ptr;
    logic [QW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          pop;
    logic          push_req;
    logic          push;

    logic [31:0]   mtime_lo;
    logic [31:0]   mtime_hi;
    logic [31:0]   rdata;

    // Address decode. The low two address bits never select a word; the
    // core extracts sub-word data itself.
    assign ram_hit  = (bus.IEUAdr >= RAM_BASE) && (bus.IEUAdr < RAM_LIMIT);
    assign mmio_hit = (bus.IEUAdr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = bus.IEUAdr[3:2];
    assign ram_idx  = AW'((bus.IEUAdr - RAM_BASE) >> 2);

    // Once halted, every store is dropped; loads keep working.
    assign store = bus.MemEn && bus.WriteEn && !Halt;
    assign load  = bus.MemEn && !bus.WriteEn;

    // RAM byte-lane writes. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (store && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.WriteByteEn[i]) begin
                    mem[ram_idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
                end
            end
        end
    end

    // Halt capture and sticky bus error. A tohost write with bit0=0 is a
    // no-op so software can write progress values without stopping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Halt     <= 1'b0;
            HaltCode <= '0;
            BusErr   <= 1'b0;
        end else begin
            if (store && mmio_hit && (mmio_off == 2'd0) &&
                bus.WriteByteEn[0] && bus.WriteData[0]) begin
                Halt     <= 1'b1;
                HaltCode <= bus.WriteData[31:1];
            end
            if (bus.MemEn && !ram_hit && !mmio_hit) begin
                BusErr <= 1'b1;
            end
        end
    end

    // Console FIFO. The extra pointer bit tells full apart from empty. A push
    // into a full FIFO still lands if the head leaves in the same cycle.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[QW] != rd_ptr[QW]) &&
                      (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);
    assign pop      = !empty && bus.ConsoleReady;
    assign push_req = store && mmio_hit && (mmio_off == 2'd1) && bus.WriteByteEn[0];
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            txq[wr_ptr[QW-1:0]] <= bus.WriteData[7:0];
        end
    end

    // Head is forced to zero while empty so nothing stale leaks out.
    assign bus.ConsoleValid = !empty;
    assign bus.ConsoleData  = empty ? 8'h00 : txq[rd_ptr[QW-1:0]];

`ifdef DMEM_MTIME_EN
    logic [63:0] mtime;

    // Free-running cycle timer; it stops counting once the program halts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (!Halt) begin
            mtime <= mtime + 64'd1;
        end
    end

    assign mtime_lo = mtime[31:0];
    assign mtime_hi = mtime[63:32];
`else
    assign mtime_lo = '0;
    assign mtime_hi = '0;
`endif

    // Combinational read mux; anything that is not a decoded load reads 0.
    always_comb begin
        rdata = '0;
        if (load) begin
            if (ram_hit) begin
                rdata = mem[ram_idx];
            end else if (mmio_hit) begin
                case (mmio_off)
                    2'd0:    rdata = {HaltCode, Halt};
                    2'd1:    rdata = {29'b0, overflow, full, empty};
                    2'd2:    rdata = mtime_lo;
                    default: rdata = mtime_hi;
                endcase
            end
        end
    end

    assign bus.ReadData = rdata;

endmodule
